// File: rtl/lbi_pkg.sv
// Shared types and sizing helpers for the multi-row message/row inner-product engine.
package lbi_pkg;

  localparam int MSG_W_DEF   = 840;
  localparam int CHUNK_W_DEF = 16;
  localparam int ELEM_W_DEF  = 6;
  localparam int ROWS_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lbi_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter width that stays at least one bit for degenerate single-chunk messages.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lbi_rows_engine_if.sv
// Bus bundle between the message loader / matrix generator / packer and the engine.
interface lbi_rows_engine_if
  import lbi_pkg::*;
#(
  parameter int MSG_W   = MSG_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int ELEM_W  = ELEM_W_DEF,
  parameter int ROWS    = ROWS_DEF
) ();

  // All handshakes transfer on a clock edge where both valid and ready are high;
  // valid never waits on ready, and the producer holds its payload until the transfer.
  logic                            msg_vld;
  logic                            msg_rdy;
  logic [MSG_W-1:0]                msg_in;
  logic                            start;
  logic                            abort;
  logic [ROWS*CHUNK_W*ELEM_W-1:0]  rand_in;
  logic                            rand_vld;
  logic                            rand_rdy;
  logic [ROWS*ELEM_W-1:0]          res_out;
  logic                            res_vld;
  logic                            res_rdy;
  logic                            busy;
  lbi_state_e                      state_dbg;

  modport master (
    output msg_vld, msg_in, start, abort, rand_in, rand_vld, res_rdy,
    input  msg_rdy, rand_rdy, res_out, res_vld, busy, state_dbg
  );

  modport slave (
    input  msg_vld, msg_in, start, abort, rand_in, rand_vld, res_rdy,
    output msg_rdy, rand_rdy, res_out, res_vld, busy, state_dbg
  );

endinterface

// File: rtl/lbi_chunk_dot.sv
// One row's contribution for one message chunk: masked elements summed mod 2^ELEM_W.
module lbi_chunk_dot #(
  parameter int CHUNK_W = 16,
  parameter int ELEM_W  = 6
) (
  input  logic [CHUNK_W-1:0]        msg_bits,
  input  logic [CHUNK_W*ELEM_W-1:0] elems,
  output logic [ELEM_W-1:0]         sum
);

  localparam int LEAVES = (CHUNK_W <= 1) ? 1 : (1 << $clog2(CHUNK_W));

  logic [ELEM_W-1:0] tree [LEAVES];

  // Pairwise in-place reduction; each pass halves the live width, giving a balanced tree.
  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      tree[i] = '0;
    end
    for (int i = 0; i < CHUNK_W; i++) begin
      if (msg_bits[i]) begin
        tree[i] = elems[i*ELEM_W +: ELEM_W];
      end
    end
    for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        tree[i] = tree[2*i] + tree[2*i+1];
      end
    end
    sum = tree[0];
  end

endmodule

// File: rtl/lbi_rows_engine.sv
// Stores one message and accumulates ROWS inner products against streamed matrix slices.
module lbi_rows_engine
  import lbi_pkg::*;
#(
  parameter int MSG_W   = MSG_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int ELEM_W  = ELEM_W_DEF,
  parameter int ROWS    = ROWS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  lbi_rows_engine_if.slave   bus
);

  localparam int NCHUNK = ceil_div(MSG_W, CHUNK_W);
  localparam int CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  lbi_state_e                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ROWS-1:0][ELEM_W-1:0]   acc_q, acc_d, dot;
  logic [NCHUNK-1:0][CHUNK_W-1:0] msg_q, msg_d;
  logic                          msg_loaded_q, msg_loaded_d;
  logic [NCHUNK*CHUNK_W-1:0]     msg_flat;
  logic [CHUNK_W-1:0]            cur_chunk;

  // Tail of the last chunk beyond MSG_W is zero so it never contributes.
  always_comb begin
    msg_flat = '0;
    msg_flat[MSG_W-1:0] = bus.msg_in;
  end

  assign cur_chunk = msg_q[cnt_q];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    lbi_chunk_dot #(
      .CHUNK_W (CHUNK_W),
      .ELEM_W  (ELEM_W)
    ) u_dot (
      .msg_bits (cur_chunk),
      .elems    (bus.rand_in[r*CHUNK_W*ELEM_W +: CHUNK_W*ELEM_W]),
      .sum      (dot[r])
    );
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    msg_d        = msg_q;
    msg_loaded_d = msg_loaded_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.msg_vld) begin
          msg_d        = msg_flat;
          msg_loaded_d = 1'b1;
        end
        if (bus.start && (msg_loaded_q || bus.msg_vld)) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (bus.rand_vld) begin
          for (int r = 0; r < ROWS; r++) begin
            acc_d[r] = acc_q[r] + dot[r];
          end
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (bus.abort) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (bus.res_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      msg_q        <= '0;
      msg_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      msg_q        <= msg_d;
      msg_loaded_q <= msg_loaded_d;
    end
  end

  assign bus.msg_rdy   = (state_q == ST_IDLE);
  assign bus.rand_rdy  = (state_q == ST_RUN);
  assign bus.res_vld   = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.res_out   = acc_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_lbi_rows_engine.sv
// Directed bench for lbi_rows_engine: latency, results, stalls, backpressure, abort, reset.
module tb_lbi_rows_engine;
  import lbi_pkg::*;

  localparam int MSG_W   = 840;
  localparam int CHUNK_W = 16;
  localparam int ELEM_W  = 6;
  localparam int ROWS    = 4;
  localparam int RW      = ROWS * CHUNK_W * ELEM_W;
  localparam int OW      = ROWS * ELEM_W;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic [MSG_W-1:0] msg_ones;
  logic [MSG_W-1:0] msg_zero;
  logic [MSG_W-1:0] msg_top;
  logic [OW-1:0]    exp_ones;

  lbi_rows_engine_if #(
    .MSG_W (MSG_W), .CHUNK_W (CHUNK_W), .ELEM_W (ELEM_W), .ROWS (ROWS)
  ) bus ();

  lbi_rows_engine #(
    .MSG_W (MSG_W), .CHUNK_W (CHUNK_W), .ELEM_W (ELEM_W), .ROWS (ROWS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.msg_vld  = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.rand_vld = 1'b0;
    bus.res_rdy  = 1'b1;
  endtask

  function automatic logic [RW-1:0] rand_rows(input int v0, input int v1, input int v2, input int v3);
    logic [RW-1:0] v;
    int vals[4];
    vals = '{v0, v1, v2, v3};
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int j = 0; j < CHUNK_W; j++) begin
        v[(r*CHUNK_W+j)*ELEM_W +: ELEM_W] = ELEM_W'(vals[r]);
      end
    end
    return v;
  endfunction

  // Starts a batch in cycle 0 and returns the cycle index at which res_vld is seen (-1 on timeout).
  task automatic run_batch(input logic [MSG_W-1:0] m, input bit load, input bit toggle,
                           input int budget, output int lat);
    bus.msg_in   = m;
    bus.msg_vld  = load;
    bus.start    = 1'b1;
    bus.rand_vld = toggle ? 1'b0 : 1'b1;
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      bus.msg_vld = 1'b0;
      bus.start   = 1'b0;
      if (bus.res_vld === 1'b1) begin
        lat = k;
        break;
      end
      bus.rand_vld = toggle ? (k % 2 == 0) : 1'b1;
    end
    bus.rand_vld = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.msg_in  = '0;
    bus.rand_in = '0;
    tick();
    tick();
    n_cmp++; if (bus.res_vld !== 1'b0) begin n_err++; $display("FAIL reset_res_vld got=%b exp=0", bus.res_vld); end
    n_cmp++; if (bus.res_out !== '0) begin n_err++; $display("FAIL reset_res_out got=%h exp=0", bus.res_out); end
    n_cmp++; if (bus.rand_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rand_rdy got=%b exp=0", bus.rand_rdy); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.msg_rdy !== 1'b1) begin n_err++; $display("FAIL reset_msg_rdy got=%b exp=1", bus.msg_rdy); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_all_ones();
    int lat;
    bus.rand_in = rand_rows(1, 2, 3, 4);
    run_batch(msg_ones, 1'b1, 1'b0, 200, lat);
    n_cmp++; if (lat !== 54) begin n_err++; $display("FAIL ones_latency got=%0d exp=54", lat); end
    n_cmp++; if (bus.res_out !== exp_ones) begin n_err++; $display("FAIL ones_result got=%h exp=%h", bus.res_out, exp_ones); end
    tick();
    n_cmp++; if (bus.res_vld !== 1'b0) begin n_err++; $display("FAIL ones_pulse got=%b exp=0", bus.res_vld); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ones_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_zero_msg();
    int lat;
    bus.rand_in = rand_rows(1, 2, 3, 4);
    run_batch(msg_zero, 1'b1, 1'b0, 200, lat);
    n_cmp++; if (lat !== 54) begin n_err++; $display("FAIL zero_latency got=%0d exp=54", lat); end
    n_cmp++; if (bus.res_out !== '0) begin n_err++; $display("FAIL zero_result got=%h exp=0", bus.res_out); end
    tick();
  endtask

  task automatic test_top_bit();
    int lat;
    logic [RW-1:0] rv;
    logic [OW-1:0] exp_v;
    // Only j=7 of chunk 52 (bit 839) is set; neighbouring elements must be masked away.
    rv = '0;
    rv[(0*CHUNK_W+7)*ELEM_W +: ELEM_W] = 6'd63;
    rv[(0*CHUNK_W+6)*ELEM_W +: ELEM_W] = 6'd5;
    rv[(1*CHUNK_W+0)*ELEM_W +: ELEM_W] = 6'd9;
    rv[(2*CHUNK_W+15)*ELEM_W +: ELEM_W] = 6'd3;
    rv[(3*CHUNK_W+8)*ELEM_W +: ELEM_W] = 6'd7;
    bus.rand_in = rv;
    exp_v = {6'd0, 6'd0, 6'd0, 6'd63};
    run_batch(msg_top, 1'b1, 1'b0, 200, lat);
    n_cmp++; if (lat !== 54) begin n_err++; $display("FAIL top_latency got=%0d exp=54", lat); end
    n_cmp++; if (bus.res_out !== exp_v) begin n_err++; $display("FAIL top_result got=%h exp=%h", bus.res_out, exp_v); end
    tick();
  endtask

  task automatic test_stall();
    int lat;
    bus.rand_in = rand_rows(1, 2, 3, 4);
    run_batch(msg_ones, 1'b1, 1'b1, 300, lat);
    n_cmp++; if (lat !== 107) begin n_err++; $display("FAIL stall_latency got=%0d exp=107", lat); end
    n_cmp++; if (bus.res_out !== exp_ones) begin n_err++; $display("FAIL stall_result got=%h exp=%h", bus.res_out, exp_ones); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    bus.rand_in = rand_rows(1, 2, 3, 4);
    bus.res_rdy = 1'b0;
    run_batch(msg_ones, 1'b1, 1'b0, 200, lat);
    n_cmp++; if (lat !== 54) begin n_err++; $display("FAIL bp_latency got=%0d exp=54", lat); end
    bus.rand_vld = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (bus.res_vld !== 1'b1) begin n_err++; $display("FAIL bp_res_vld c=%0d got=%b exp=1", c, bus.res_vld); end
      n_cmp++; if (bus.res_out !== exp_ones) begin n_err++; $display("FAIL bp_res_out c=%0d got=%h exp=%h", c, bus.res_out, exp_ones); end
      n_cmp++; if (bus.msg_rdy !== 1'b0) begin n_err++; $display("FAIL bp_msg_rdy c=%0d got=%b exp=0", c, bus.msg_rdy); end
      n_cmp++; if (bus.rand_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rand_rdy c=%0d got=%b exp=0", c, bus.rand_rdy); end
      tick();
    end
    bus.rand_vld = 1'b0;
    bus.res_rdy  = 1'b1;
    tick();
    n_cmp++; if (bus.res_vld !== 1'b0) begin n_err++; $display("FAIL bp_release_vld got=%b exp=0", bus.res_vld); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_release_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.msg_rdy !== 1'b1) begin n_err++; $display("FAIL bp_release_msg_rdy got=%b exp=1", bus.msg_rdy); end
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    bus.rand_in  = rand_rows(1, 2, 3, 4);
    bus.msg_in   = msg_ones;
    bus.msg_vld  = 1'b1;
    bus.start    = 1'b1;
    bus.rand_vld = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      bus.msg_vld = 1'b0;
      bus.start   = 1'b0;
    end
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.rand_vld = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.rand_rdy !== 1'b0) begin n_err++; $display("FAIL abort_rand_rdy got=%b exp=0", bus.rand_rdy); end
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.res_vld === 1'b1) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_result got=%0d exp=0", seen); end
    run_batch(msg_zero, 1'b0, 1'b0, 200, lat);
    n_cmp++; if (lat !== 54) begin n_err++; $display("FAIL reuse_latency got=%0d exp=54", lat); end
    n_cmp++; if (bus.res_out !== exp_ones) begin n_err++; $display("FAIL reuse_result got=%h exp=%h", bus.res_out, exp_ones); end
    tick();
  endtask

  task automatic test_async_reset();
    int seen;
    bus.rand_in  = rand_rows(1, 2, 3, 4);
    bus.msg_in   = msg_ones;
    bus.msg_vld  = 1'b1;
    bus.start    = 1'b1;
    bus.rand_vld = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      bus.msg_vld = 1'b0;
      bus.start   = 1'b0;
    end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.rand_rdy !== 1'b0) begin n_err++; $display("FAIL areset_rand_rdy got=%b exp=0", bus.rand_rdy); end
    n_cmp++; if (bus.msg_rdy !== 1'b1) begin n_err++; $display("FAIL areset_msg_rdy got=%b exp=1", bus.msg_rdy); end
    n_cmp++; if (bus.res_vld !== 1'b0) begin n_err++; $display("FAIL areset_res_vld got=%b exp=0", bus.res_vld); end
    n_cmp++; if (bus.res_out !== '0) begin n_err++; $display("FAIL areset_res_out got=%h exp=0", bus.res_out); end
    bus.rand_vld = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL nomsg_start_busy got=%b exp=0", bus.busy); end
    bus.rand_vld = 1'b1;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.res_vld === 1'b1 || bus.busy === 1'b1) seen++;
      tick();
    end
    bus.rand_vld = 1'b0;
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL nomsg_activity got=%0d exp=0", seen); end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    msg_ones = '1;
    msg_zero = '0;
    msg_top  = '0;
    msg_top[839] = 1'b1;
    // 840*k mod 64 for row k = 1..4
    exp_ones = {6'd32, 6'd24, 6'd16, 6'd8};
    test_reset();
    test_all_ones();
    test_zero_msg();
    test_top_bit();
    test_stall();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lbi_rows_engine.md
Name: lbi_rows_engine

Overview:
- Multi-row successor to the single-row LBMIV message/row engine.
- Computes ROWS inner products of one stored message vector against ROWS rows of a streamed random matrix, in parallel, modulo 2^ELEM_W.
- Random-matrix slices arrive one chunk per handshake; the stored message can be reused across many row batches.
- Sits between the message loader and the random-matrix generator; results feed the signature/packing stage.

Parameters:
- MSG_W, 840, message width in bits.
- CHUNK_W, 16, message bits consumed per round.
- ELEM_W, 6, random element and accumulator width; arithmetic is mod 2^ELEM_W.
- ROWS, 4, number of rows computed in parallel.
- NCHUNK (localparam), ceil(MSG_W/CHUNK_W) = 53; the message is zero-padded to NCHUNK*CHUNK_W bits.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- msg_in  in  MSG_W  message vector.
- msg_vld  in  1  message valid.
- msg_rdy  out  1  message can be accepted.
- start  in  1  begin a row batch.
- abort  in  1  cancel the current batch.
- rand_in  in  ROWS*CHUNK_W*ELEM_W  random slice; element (r,j) is at [(r*CHUNK_W+j)*ELEM_W +: ELEM_W].
- rand_vld  in  1  random slice valid.
- rand_rdy  out  1  slice is consumed this cycle.
- res_out  out  ROWS*ELEM_W  row results; row r at [r*ELEM_W +: ELEM_W].
- res_vld  out  1  results valid.
- res_rdy  in  1  downstream accepts results.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous) values:
  - state=IDLE, cnt=0, acc[*]=0, msg register=0, msg_loaded=0.
  - Outputs: res_vld=0, res_out=0, rand_rdy=0, busy=0, msg_rdy=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - msg_rdy=1. On msg_vld the padded message is captured and msg_loaded is set.
  - start is accepted when (msg_loaded | msg_vld). If msg_vld and start coincide, the batch uses the new message.
  - On start: acc[*]=0, cnt=0, go to RUN. A start with no message is ignored.
- RUN:
  - rand_rdy=1 and msg_rdy=0.
  - On rand_vld: acc[r] <= acc[r] + sum over j of (msg[cnt*CHUNK_W+j] ? rand(r,j) : 0), truncated to ELEM_W bits, for every r.
  - cnt increments per accepted slice. When slice cnt==NCHUNK-1 is consumed, go to DONE.
  - rand_vld=0 stalls; no accumulation occurs that cycle.
- DONE:
  - res_vld=1 and res_out=acc, stable until res_rdy.
  - On res_vld & res_rdy: go to IDLE. res_vld drops the next cycle; acc is held.
- msg_loaded persists across batches. A new message is accepted only in IDLE.
- abort (RUN or DONE): go to IDLE next cycle, acc cleared, no res_vld. Results already presented in DONE are withdrawn. abort is ignored in IDLE. abort takes priority over a simultaneous rand_vld or res_rdy.
- Latency: with start accepted in cycle 0 and rand_vld held high, res_vld asserts in cycle NCHUNK+1 (54 at defaults). Each stalled cycle adds one.
- busy=1 in RUN and DONE.
- Bits of the final chunk beyond MSG_W read as 0.
- cnt is clog2(NCHUNK) bits wide and never wraps within a batch.
- Reset asserted mid-batch: all state cleared immediately and no res_vld is produced.

Decomposition:
- Package lbi_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - a ceil-div function and clog2 helpers;
  - the default ELEM_W/CHUNK_W constants.
- Sub-module lbi_chunk_dot:
  - Combinational, parameterised CHUNK_W/ELEM_W.
  - Masks CHUNK_W elements by message bits and reduces them with a balanced adder tree mod 2^ELEM_W.
  - Instantiated ROWS times under generate.

Test Plan:
- Message all ones, every rand element of row r = r+1, rand_vld held high → res_out rows = 8, 16, 24, 32 (840·k mod 64). res_vld at cycle 54 after start; single-cycle pulse with res_rdy=1.
- Message = 0 → all rows 0. Message with only bit 839 set and rand(row0, j=7)=63 on chunk 52 → row0 = 63, other rows 0.
- rand_vld toggled every other cycle → same results as the first scenario; res_vld at cycle 107 after start; acc unchanged on stalled cycles.
- res_rdy held low 10 cycles in DONE → res_out and res_vld stable, msg_rdy=0, rand_rdy=0. Release → IDLE next cycle.
- abort after 20 slices → busy=0 next cycle, no res_vld. A following start reuses the stored message and reproduces the first scenario's results.
- Reset pulsed asynchronously (between clock edges) mid-RUN → outputs return to reset values immediately. start without a reloaded message is ignored (busy stays 0).
